cdc_handshake_tx: RTL and testbench

Source-side half of a four-phase-free toggle handshake for moving a multi-bit word into another clock domain. It accepts a word on a valid/ready interface in its own clock domain and holds it stable on `tx_data`. It flips `req_toggle` and waits until the destination's `ack_toggle`, brought in through an internal 2-stage synchronizer, matches `req_toggle`. It then accepts the next word. It pairs with the destination-side receiver, which synchronizes `req_toggle`, captures `tx_data` and echoes the toggle back.

---
 rtl/cdc_handshake_tx.sv | 120 ++++++++++++
 tb/tb_cdc_handshake_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source half of a toggle-based CDC handshake.
// A word accepted on in_valid/in_ready is held on tx_data. The block
// flips req_toggle and waits for the synchronized ack_toggle to match it
// before it accepts the next word.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  req_toggle,
  input  logic                  ack_toggle,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_protocol
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_ACK = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  (* ASYNC_REG = "TRUE" *) logic r_ack_meta;
  (* ASYNC_REG = "TRUE" *) logic r_ack_sync;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_req_toggle;
  logic                  r_err_protocol;
  logic                  w_accept;
  logic                  w_ack_match;
  logic                  w_waiting;

  // Two-flop synchronizer for the asynchronous acknowledge toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_meta <= 1'b0;
      r_ack_sync <= 1'b0;
    end else begin
      r_ack_meta <= ack_toggle;
      r_ack_sync <= r_ack_meta;
    end
  end

  // The transfer is complete once the echoed toggle equals our request
  assign w_ack_match = (r_ack_sync == r_req_toggle);
  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_waiting   = (r_state == S_WAIT_ACK) && !w_ack_match;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a pending transfer is never abandoned
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (in_valid)    w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (w_ack_match) w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the word and flip the request on the same accept edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_data    <= '0;
      r_req_toggle <= 1'b0;
    end else if (w_accept) begin
      r_tx_data    <= in_data;
      r_req_toggle <= ~r_req_toggle;
    end
  end

  // Sticky flag: acknowledge moved while nothing was outstanding
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  r_err_protocol <= 1'b0;
    else if ((r_state == S_IDLE) && !w_ack_match)  r_err_protocol <= 1'b1;
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0]  LIMIT    = CW'(TIMEOUT_CYCLES);
      localparam logic [CW-1:0]  LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] r_cnt;
      logic          r_err_timeout;

      // Saturating wait counter; the flag sets on the edge it reaches LIMIT
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt         <= '0;
          r_err_timeout <= 1'b0;
        end else if (w_accept) begin
          r_cnt <= '0;
        end else if (w_waiting && (r_cnt != LIMIT)) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LIMIT_M1) r_err_timeout <= 1'b1;
        end
      end

      assign err_timeout = r_err_timeout;
    end else begin : g_no_timeout
      assign err_timeout = 1'b0;
    end
  endgenerate

  assign in_ready     = (r_state == S_IDLE);
  assign busy         = (r_state == S_WAIT_ACK);
  assign tx_data      = r_tx_data;
  assign req_toggle   = r_req_toggle;
  assign err_protocol = r_err_protocol;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: table-driven cycle vectors, hand sequences for
// reset/timeout/protocol corners, and a randomized stream against an
// independent destination model on an unrelated clock.
module tb_cdc_handshake_tx;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          dclk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] tx_data;
  logic          req_toggle;
  logic          ack_toggle;
  logic          busy;
  logic          err_timeout;
  logic          err_protocol;

  logic          man_ack;
  logic          dest_ack;
  logic          dest_en;

  int errors = 0;
  int checks = 0;

  cdc_handshake_tx #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .tx_data      (tx_data),
    .req_toggle   (req_toggle),
    .ack_toggle   (ack_toggle),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_protocol (err_protocol)
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #7 dclk = ~dclk;
  end

  assign ack_toggle = dest_en ? dest_ack : man_ack;

  // Destination model: synchronize req, capture the word, echo after a delay
  logic          d_meta = 1'b0;
  logic          d_sync = 1'b0;
  logic          d_seen = 1'b0;
  logic [DW-1:0] captured[$];

  always @(posedge dclk) begin
    d_meta <= req_toggle;
    d_sync <= d_meta;
  end

  initial begin
    forever begin
      @(posedge dclk);
      if (dest_en && (d_sync !== d_seen)) begin
        captured.push_back(tx_data);
        d_seen = d_sync;
        repeat ($urandom_range(0, 20)) @(posedge dclk);
        dest_ack = d_seen;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One source cycle: inputs are driven 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          ack;
    logic          rdy;
    logic          bsy;
    logic          req;
    logic [DW-1:0] tx;
  } vec_t;

  vec_t tbl[13];

  task automatic setv(input int i, input logic v, input logic [DW-1:0] d, input logic a,
                      input logic rdy, input logic bsy, input logic req, input logic [DW-1:0] tx);
    tbl[i].v = v; tbl[i].d = d; tbl[i].ack = a;
    tbl[i].rdy = rdy; tbl[i].bsy = bsy; tbl[i].req = req; tbl[i].tx = tx;
  endtask

  logic          exp_req;
  logic          rdy_before;
  logic          req_prev;
  int            idx;
  int            cyc;
  int            tog;

  initial begin
    // Single transfer of A5 (echo 5 cycles later), a coincident in_valid at
    // completion that must not be taken, then 5A accepted one edge later.
    setv(0,  1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
    setv(1,  1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
    setv(2,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
    setv(3,  1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
    setv(4,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
    setv(5,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5);
    setv(6,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5);
    setv(7,  1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
    setv(8,  1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
    setv(9,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
    setv(10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
    setv(11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    setv(12, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);

    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    man_ack  = 1'b0;
    dest_ack = 1'b0;
    dest_en  = 1'b0;

    // Reset asserted between edges: outputs must clear with no clock
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", req_toggle, 0);
    chk("rst_tx", tx_data, 0);
    chk("rst_errt", err_timeout, 0);
    chk("rst_errp", err_protocol, 0);
    step(); step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("rel_ready", in_ready, 1);
    chk("rel_errp", err_protocol, 0);
    chk("rel_errt", err_timeout, 0);

    // Table-driven cycle vectors
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      man_ack  = tbl[i].ack;
      step();
      chk($sformatf("vec%0d_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d_req", i), req_toggle, tbl[i].req);
      chk($sformatf("vec%0d_tx", i), tx_data, tbl[i].tx);
      chk($sformatf("vec%0d_errp", i), err_protocol, 0);
    end
    in_valid = 1'b0;
    chk("vec_errt", err_timeout, 0);

    // Protocol error: ack moves while idle, flag appears on the third edge
    man_ack = 1'b1;
    step(); chk("perr_e1", err_protocol, 0);
    step(); chk("perr_e2", err_protocol, 0);
    step(); chk("perr_e3", err_protocol, 1);
    repeat (3) step();
    chk("perr_sticky", err_protocol, 1);
    chk("perr_ready", in_ready, 1);
    man_ack = 1'b0;

    // Reset mid-transfer
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    chk("mid_tx", tx_data, 8'h3C);
    chk("mid_req", req_toggle, 1);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", req_toggle, 0);
    chk("mid_rst_tx", tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    step();
    reset_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 8'hC3;
    step();
    in_valid = 1'b0;
    chk("c3_tx", tx_data, 8'hC3);
    chk("c3_req", req_toggle, 1);
    repeat (3) step();
    man_ack = 1'b1;
    step(); step();
    chk("c3_busy", busy, 1);
    step();
    chk("c3_ready", in_ready, 1);
    chk("c3_tx_held", tx_data, 8'hC3);
    chk("c3_errp", err_protocol, 0);

    // Timeout: accept, never echo; flag after exactly TO waiting cycles
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    chk("to_req", req_toggle, 0);
    for (int i = 1; i <= TO; i++) begin
      step();
      chk($sformatf("to_flag_%0d", i), err_timeout, (i == TO) ? 1 : 0);
      chk($sformatf("to_busy_%0d", i), busy, 1);
    end
    repeat (5) step();
    chk("to_still_busy", busy, 1);
    man_ack = 1'b0;
    step(); step(); step();
    chk("to_late_ready", in_ready, 1);
    chk("to_late_flag", err_timeout, 1);
    chk("to_tx", tx_data, 8'h77);

    // Randomized stream of 01..10 against the destination model
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (4) @(posedge dclk);
    d_seen   = 1'b0;
    dest_ack = 1'b0;
    captured.delete();
    dest_en  = 1'b1;
    step();
    exp_req  = 1'b0;
    req_prev = req_toggle;
    tog      = 0;
    idx      = 0;
    cyc      = 0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    while (idx < 16 && cyc < 4000) begin
      rdy_before = in_ready;
      step();
      cyc++;
      if (req_toggle !== req_prev) tog++;
      req_prev = req_toggle;
      if (rdy_before) begin
        exp_req = ~exp_req;
        chk($sformatf("str_tx_%0d", idx), tx_data, idx + 1);
        chk($sformatf("str_req_%0d", idx), req_toggle, exp_req);
        idx++;
        in_data = DW'(idx + 1);
      end
    end
    in_valid = 1'b0;
    chk("str_all_accepted", idx, 16);
    cyc = 0;
    while (busy && cyc < 1000) begin
      step();
      cyc++;
      if (req_toggle !== req_prev) tog++;
      req_prev = req_toggle;
    end
    chk("str_drained", busy, 0);
    repeat (10) step();
    if (req_toggle !== req_prev) tog++;
    chk("str_toggles", tog, 16);
    chk("str_count", captured.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < captured.size())
        chk($sformatf("str_cap_%0d", i), captured[i], i + 1);
    end
    chk("str_errp", err_protocol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
